// File: rtl/hub75_pkg.sv
// Shared types and panel geometry for the HUB75 scan driver and the pattern sources.
package hub75_pkg;

    localparam int PANEL_COLS      = 64;
    localparam int PANEL_ROW_PAIRS = 32;
    localparam int COL_W           = 6;
    localparam int LINE_W          = 5;
    localparam int DATA_W          = 6;

    typedef enum logic [1:0] {
        ST_BLANK   = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_DISPLAY = 2'd3
    } scan_state_t;

    // Bit order {r1, g1, b1, r2, g2, b2}
    typedef logic [DATA_W-1:0] rgb_pair_t;

endpackage

// File: rtl/hub75_scan_driver.sv
// Row-pair scan sequencer for a 64x64 1/32-scan HUB75 panel: prefetches pattern bits,
// shifts them out on p_clk, latches the row pair and holds the LEDs on for ON_CYCLES.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_BLANK   | LEDs off, column 0 presented to the pattern source
// ST_SHIFT   | 64 columns clocked out, column address one ahead of p_* data
// ST_LATCH   | p_lat high for one cycle, p_addr takes the new row pair
// ST_DISPLAY | LEDs on for ON_CYCLES, then advance line
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int HALF_PERIOD = 1,
    parameter int ON_CYCLES   = 128
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LINE_W-1:0] line,
    output logic [COL_W-1:0]  column,
    input  logic              r1,
    input  logic              g1,
    input  logic              b1,
    input  logic              r2,
    input  logic              g2,
    input  logic              b2,
    output logic              p_r1,
    output logic              p_g1,
    output logic              p_b1,
    output logic              p_r2,
    output logic              p_g2,
    output logic              p_b2,
    output logic              p_clk,
    output logic              p_lat,
    output logic              p_oe_n,
    output logic [LINE_W-1:0] p_addr,
    output logic              frame_start
);

    localparam int PH_W = $clog2(HALF_PERIOD + 1);
    localparam int ON_W = $clog2(ON_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(HALF_PERIOD - 1);
    localparam logic [ON_W-1:0] ON_LOAD = ON_W'(ON_CYCLES - 1);

    scan_state_t       state, state_d;
    logic              primed;
    logic [PH_W-1:0]   phase_cnt, phase_d;
    logic [ON_W-1:0]   on_cnt, on_d;
    logic [LINE_W-1:0] line_d, next_line, p_addr_d;
    logic [COL_W-1:0]  column_d, next_column;
    rgb_pair_t         data_q, data_d, pattern;
    logic              p_clk_d, p_lat_d, p_oe_n_d, frame_start_d;
    logic              phase_done, on_done, last_col;

    assign pattern     = {r1, g1, b1, r2, g2, b2};
    assign {p_r1, p_g1, p_b1, p_r2, p_g2, p_b2} = data_q;

    assign phase_done  = (phase_cnt == '0);
    assign on_done     = (on_cnt == '0);
    // Column has already wrapped to 0 while the 64th column is on the wire.
    assign last_col    = (column == '0);
    assign next_column = column + COL_W'(1);
    assign next_line   = line + LINE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BLANK;
            primed      <= 1'b0;
            phase_cnt   <= '0;
            on_cnt      <= '0;
            line        <= '0;
            column      <= '0;
            p_addr      <= '0;
            data_q      <= '0;
            p_clk       <= 1'b0;
            p_lat       <= 1'b0;
            p_oe_n      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_d;
            primed      <= 1'b1;
            phase_cnt   <= phase_d;
            on_cnt      <= on_d;
            line        <= line_d;
            column      <= column_d;
            p_addr      <= p_addr_d;
            data_q      <= data_d;
            p_clk       <= p_clk_d;
            p_lat       <= p_lat_d;
            p_oe_n      <= p_oe_n_d;
            frame_start <= frame_start_d;
        end
    end

    // The first BLANK after reset is spent arming; the next one carries frame_start.
    always_comb begin
        state_d = state;
        case (state)
            ST_BLANK:   if (primed) state_d = ST_SHIFT;
            ST_SHIFT:   if (p_clk && phase_done && last_col) state_d = ST_LATCH;
            ST_LATCH:   state_d = ST_DISPLAY;
            ST_DISPLAY: if (on_done) state_d = ST_BLANK;
            default:    state_d = ST_BLANK;
        endcase
    end

    always_comb begin
        phase_d       = phase_cnt;
        on_d          = on_cnt;
        line_d        = line;
        column_d      = column;
        p_addr_d      = p_addr;
        data_d        = data_q;
        p_clk_d       = 1'b0;
        p_lat_d       = 1'b0;
        p_oe_n_d      = 1'b1;
        frame_start_d = 1'b0;
        case (state)
            ST_BLANK: begin
                if (primed) begin
                    data_d   = pattern;
                    column_d = next_column;
                    phase_d  = PH_LOAD;
                end else begin
                    column_d      = '0;
                    frame_start_d = (line == '0);
                end
            end
            ST_SHIFT: begin
                p_clk_d = p_clk;
                if (!phase_done) begin
                    phase_d = phase_cnt - PH_W'(1);
                end else if (!p_clk) begin
                    p_clk_d = 1'b1;
                    phase_d = PH_LOAD;
                end else if (last_col) begin
                    p_clk_d  = 1'b0;
                    p_lat_d  = 1'b1;
                    p_addr_d = line;
                end else begin
                    p_clk_d  = 1'b0;
                    data_d   = pattern;
                    column_d = next_column;
                    phase_d  = PH_LOAD;
                end
            end
            ST_LATCH: begin
                p_oe_n_d = 1'b0;
                on_d     = ON_LOAD;
            end
            ST_DISPLAY: begin
                if (on_done) begin
                    line_d        = next_line;
                    column_d      = '0;
                    frame_start_d = (next_line == '0);
                end else begin
                    p_oe_n_d = 1'b0;
                    on_d     = on_cnt - ON_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
